// File: rtl/hazard_pkg.sv
// Shared types and default parameters for the hazard/scoreboard unit.
package hazard_pkg;
    localparam int DEF_NREG  = 32;
    localparam int DEF_MDLAT = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10,
        FWD_MD = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline-side signal bundle between the datapath and the hazard unit.
interface hazard_scoreboard_if
    import hazard_pkg::*;
#(
    parameter int NREG = DEF_NREG
);
    localparam int REGW = $clog2(NREG);

    logic [REGW-1:0] RsD, RtD, RsE, RtE;
    logic [REGW-1:0] writeregD, writeregE, writeregM, writeregW;
    logic            regwriteD, regwriteE, regwriteM, regwriteW;
    logic [1:0]      memtoregE, memtoregM;
    logic            branchD, branchneD, jumppcD;
    logic            mdopD, mdstartE;
    logic [REGW-1:0] mdwriteregE;

    logic            stallF, stallD, flushE;
    logic            forwardAD, forwardBD;
    fwd_sel_t        forwardAE, forwardBE;
    logic            mdbusy, mdwb;
    logic [REGW-1:0] mdwritereg;

    modport master (
        output RsD, RtD, RsE, RtE, writeregD, writeregE, writeregM, writeregW,
        output regwriteD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        output branchD, branchneD, jumppcD, mdopD, mdstartE, mdwriteregE,
        input  stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
        input  mdbusy, mdwb, mdwritereg
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, writeregD, writeregE, writeregM, writeregW,
        input  regwriteD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
        input  branchD, branchneD, jumppcD, mdopD, mdstartE, mdwriteregE,
        output stallF, stallD, flushE, forwardAD, forwardBD, forwardAE, forwardBE,
        output mdbusy, mdwb, mdwritereg
    );
endinterface

// File: rtl/md_tracker.sv
// Tracks the single in-flight multiply/divide op: latency countdown, pending
// destination, write-back strobe and pending-register matches for D-stage queries.
//
// state | meaning
// IDLE  | no MD op in flight
// BUSY  | MD op in flight; cnt==0 is the write-back cycle
module md_tracker
    import hazard_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int MDLAT = DEF_MDLAT,
    localparam int REGW = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mdstart,
    input  logic [REGW-1:0]      mddest,
    input  logic [2:0][REGW-1:0] qreg,
    output logic [2:0]           pend,
    output logic                 active,
    output logic                 mdbusy,
    output logic                 mdwb,
    output logic [REGW-1:0]      mdwritereg
);
    localparam int CW = 4;
    localparam logic [CW-1:0] RELOAD = CW'(MDLAT - 1);

    md_state_t       state, state_nx;
    logic [CW-1:0]   cnt;
    logic [REGW-1:0] pdest;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (mdstart) state_nx = BUSY;
            BUSY: if (cnt == '0 && !mdstart) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A start while counting down is illegal and deliberately ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            pdest <= '0;
        end else if (mdstart && (state == IDLE || cnt == '0)) begin
            cnt   <= RELOAD;
            pdest <= mddest;
        end else if (state == BUSY && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_comb begin
        mdbusy     = (state == BUSY);
        mdwb       = (state == BUSY) && (cnt == '0);
        active     = (state == BUSY) && (cnt != '0);
        mdwritereg = mdwb ? pdest : '0;
        for (int i = 0; i < 3; i++)
            pend[i] = active && (qreg[i] != '0) && (qreg[i] == pdest);
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage core: forwarding selects, load-use/branch stalls
// and multiply/divide structural and RAW/WAW stalls.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG  = DEF_NREG,
    parameter int MDLAT = DEF_MDLAT
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave hif
);
    localparam int REGW = $clog2(NREG);

    logic [2:0] pend;
    logic       active;
    logic       lwstall, branchstall, mdstall;
    logic       unused_bits;

    function automatic logic hit(input logic [REGW-1:0] src, input logic [REGW-1:0] dst,
                                 input logic en);
        return en && (src != '0) && (src == dst);
    endfunction

    function automatic fwd_sel_t fwd_e(input logic [REGW-1:0] src);
        if (hit(src, hif.writeregM, hif.regwriteM))   return FWD_M;
        if (hit(src, hif.mdwritereg, hif.mdwb))       return FWD_MD;
        if (hit(src, hif.writeregW, hif.regwriteW))   return FWD_W;
        return FWD_RF;
    endfunction

    md_tracker #(.NREG(NREG), .MDLAT(MDLAT)) u_md (
        .clk       (clk),
        .reset     (reset),
        .mdstart   (hif.mdstartE),
        .mddest    (hif.mdwriteregE),
        .qreg      ({hif.writeregD, hif.RtD, hif.RsD}),
        .pend      (pend),
        .active    (active),
        .mdbusy    (hif.mdbusy),
        .mdwb      (hif.mdwb),
        .mdwritereg(hif.mdwritereg)
    );

    assign unused_bits = ^{hif.memtoregE[1], hif.memtoregM[1]};

    always_comb begin
        lwstall = hif.memtoregE[0] &&
                  (hit(hif.RsD, hif.writeregE, hif.regwriteE) ||
                   hit(hif.RtD, hif.writeregE, hif.regwriteE));
        branchstall = (hif.branchD || hif.branchneD || hif.jumppcD) &&
                      (hit(hif.RsD, hif.writeregE, hif.regwriteE) ||
                       hit(hif.RtD, hif.writeregE, hif.regwriteE) ||
                       hit(hif.RsD, hif.writeregM, hif.memtoregM[0]) ||
                       hit(hif.RtD, hif.writeregM, hif.memtoregM[0]));
        mdstall = (hif.mdopD && active) || pend[0] || pend[1] ||
                  (hif.regwriteD && pend[2]);
    end

    assign hif.stallD    = lwstall || branchstall || mdstall;
    assign hif.stallF    = hif.stallD;
    assign hif.flushE    = hif.stallD;
    assign hif.forwardAD = hit(hif.RsD, hif.writeregM, hif.regwriteM);
    assign hif.forwardBD = hit(hif.RtD, hif.writeregM, hif.regwriteM);
    assign hif.forwardAE = fwd_e(hif.RsE);
    assign hif.forwardBE = fwd_e(hif.RtE);
endmodule
